// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational instruction
// memory, and holds the fetched word in an IF/ID register with a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned MEM_WORDS   = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        busy,
  output logic        halted,
  output logic        range_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        range_err_q, range_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic advance;
  logic pc_oob;
  logic is_halt_op;

  // Branch targets are forced word-aligned, so the low address bits are dropped.
  logic unused_br_lsb;
  assign unused_br_lsb = ^branch_addr[1:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign advance    = (state_q == ST_RUN) & ~freeze & ~branch_taken &
                      (~id_valid_q | id_ready);
  assign pc_oob     = {2'b00, pc_q[31:2]} >= MEM_WORDS_L;
  assign is_halt_op = (imem_data[31:26] == HALT_OPCODE);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    range_err_d = range_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          cnt_d   = 16'd0;
        end
      end
      ST_HALT: begin
        id_valid_d = 1'b0;
        if (start) begin
          state_d     = ST_RUN;
          pc_d        = RESET_PC;
          cnt_d       = 16'd0;
          range_err_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over freeze: the wrong-path word is flushed.
          pc_d       = {branch_addr[31:2], 2'b00};
          id_valid_d = 1'b0;
          id_inst_d  = 32'd0;
        end else if (advance && pc_oob) begin
          state_d     = ST_HALT;
          range_err_d = 1'b1;
          id_valid_d  = 1'b0;
        end else if (advance && is_halt_op) begin
          state_d    = ST_HALT;
          id_valid_d = 1'b0;
        end else if (advance) begin
          id_inst_d  = imem_data;
          id_pc_d    = pc_q + 32'd4;
          id_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          cnt_d      = sat_inc(cnt_q);
        end else if (id_valid_q && id_ready && freeze) begin
          id_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'd0;
      id_inst_q   <= 32'd0;
      id_valid_q  <= 1'b0;
      range_err_q <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      range_err_q <= range_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign busy        = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign range_err   = range_err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic, checked
// against a behavioural model through a check queue and a transfer scoreboard.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, start = 1'b0, freeze = 1'b0, branch_taken = 1'b0, id_ready = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] imem_addr, imem_data, id_pc, id_inst;
  logic        id_valid, busy, halted, range_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [32];
  assign imem_data = (imem_addr[31:7] == 25'd0) ? mem[imem_addr[6:2]] : 32'd0;

  fetch_sequencer #(.MEM_WORDS(32), .RESET_PC(32'h0), .HALT_OPCODE(6'b111111)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .busy(busy), .halted(halted), .range_err(range_err), .fetch_count(fetch_count)
  );

  localparam int S_ADDR = 0, S_VLD = 1, S_INST = 2, S_IDPC = 3,
                 S_BUSY = 4, S_HALT = 5, S_RERR = 6, S_CNT = 7;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] xfer_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          done = 1'b0;

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int          m_mode = 0;
  logic [31:0] m_pc = 32'd0, m_inst = 32'd0, m_idpc = 32'd0;
  bit          m_v = 1'b0, m_rerr = 1'b0, m_init = 1'b0;
  int          m_cnt = 0;

  function automatic logic [31:0] sig(int s);
    case (s)
      S_ADDR:  return imem_addr;
      S_VLD:   return {31'd0, id_valid};
      S_INST:  return id_inst;
      S_IDPC:  return id_pc;
      S_BUSY:  return {31'd0, busy};
      S_HALT:  return {31'd0, halted};
      S_RERR:  return {31'd0, range_err};
      default: return {16'd0, fetch_count};
    endcase
  endfunction

  function automatic logic [31:0] mword(logic [31:0] a);
    if (a[31:2] < 30'd32) return mem[a[6:2]];
    return 32'd0;
  endfunction

  task automatic expect_(string n, int s, logic [31:0] e);
    chk_t c;
    c.sel = s; c.exp = e; c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic model_step(bit rn, bit st, bit fz, bit br, logic [31:0] ba, bit rd);
    logic [31:0] w;
    if (!rn) begin
      m_mode = 0; m_pc = 32'd0; m_v = 0; m_inst = 0; m_idpc = 0; m_rerr = 0; m_cnt = 0;
      m_init = 1'b1;
    end else if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_pc = 32'd0; m_cnt = 0; end
    end else if (m_mode == 2) begin
      m_v = 0;
      if (st) begin m_mode = 1; m_pc = 32'd0; m_cnt = 0; m_rerr = 0; end
    end else if (br) begin
      m_pc = {ba[31:2], 2'b00}; m_v = 0; m_inst = 0;
    end else if (!fz && (!m_v || rd)) begin
      w = mword(m_pc);
      if ((m_pc >> 2) >= 32) begin
        m_mode = 2; m_rerr = 1; m_v = 0;
      end else if (w[31:26] == 6'h3F) begin
        m_mode = 2; m_v = 0;
      end else begin
        m_inst = w; m_idpc = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end else if (m_v && rd && fz) begin
      m_v = 0;
    end
  endtask

  task automatic cyc(bit rn, bit st, bit fz, bit br, logic [31:0] ba, bit rd);
    if (m_init) begin
      expect_("imem_addr", S_ADDR, m_pc);
      expect_("id_valid", S_VLD, {31'd0, m_v});
      expect_("id_inst", S_INST, m_inst);
      expect_("id_pc", S_IDPC, m_idpc);
      expect_("busy", S_BUSY, {31'd0, m_mode == 1});
      expect_("halted", S_HALT, {31'd0, m_mode == 2});
      expect_("range_err", S_RERR, {31'd0, m_rerr});
      expect_("fetch_count", S_CNT, 32'(m_cnt));
    end
    rst_n = rn; start = st; freeze = fz; branch_taken = br; branch_addr = ba; id_ready = rd;
    if (m_v && rd) xfer_q.push_back({m_idpc, m_inst});
    model_step(rn, st, fz, br, ba, rd);
    @(posedge clk); #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? {6'h3F, 26'($urandom)} : {1'b0, 31'($urandom)};
  endtask

  // Monitor: drains pending checks and scores every IF/ID transfer.
  initial begin
    chk_t        c;
    logic [31:0] a;
    logic [63:0] x;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        a = sig(c.sel);
        checks++;
        if (a === c.exp) passes++;
        else $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
      end
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        checks++;
        if (xfer_q.size() == 0) begin
          $display("FAIL xfer: got pc=%h inst=%h expected no transfer", id_pc, id_inst);
        end else begin
          x = xfer_q.pop_front();
          if ({id_pc, id_inst} === x) passes++;
          else $display("FAIL xfer: got pc=%h inst=%h expected pc=%h inst=%h",
                        id_pc, id_inst, x[63:32], x[31:0]);
        end
      end
      if (done) begin
        checks++;
        if (xfer_q.size() == 0) passes++;
        else $display("FAIL xfer_drain: got %0d pending expected 0", xfer_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) mem[i] = {1'b0, 31'($urandom)};
    mem[0] = 32'h8001060A; mem[1] = 32'h04011000; mem[2] = 32'hFC000000;
    mem[3] = 32'h8C220004; mem[4] = 32'h00221820;

    cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    expect_("rst_addr", S_ADDR, 32'h0); expect_("rst_valid", S_VLD, 0);
    expect_("rst_busy", S_BUSY, 0); expect_("rst_halted", S_HALT, 0);
    expect_("rst_cnt", S_CNT, 0); expect_("rst_rerr", S_RERR, 0);

    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("w0_inst", S_INST, 32'h8001060A); expect_("w0_pc", S_IDPC, 32'h4);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("w1_inst", S_INST, 32'h04011000); expect_("w1_pc", S_IDPC, 32'h8);
    expect_("w1_cnt", S_CNT, 2);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("hop_halted", S_HALT, 1); expect_("hop_busy", S_BUSY, 0);
    expect_("hop_valid", S_VLD, 0); expect_("hop_cnt", S_CNT, 2);
    expect_("hop_rerr", S_RERR, 0);

    mem[2] = 32'h00430820;
    cyc(1, 1, 0, 0, 0, 1);
    expect_("restart_addr", S_ADDR, 32'h0); expect_("restart_cnt", S_CNT, 0);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("refetch_cnt", S_CNT, 1); expect_("refetch_inst", S_INST, 32'h8001060A);
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 1);
    expect_("frz_addr", S_ADDR, 32'h8); expect_("frz_valid", S_VLD, 0);
    expect_("frz_inst", S_INST, 32'h04011000); expect_("frz_pc", S_IDPC, 32'h8);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("resume_inst", S_INST, 32'h00430820); expect_("resume_pc", S_IDPC, 32'hC);

    cyc(1, 0, 1, 1, 32'h0000000E, 1);
    expect_("br_addr", S_ADDR, 32'hC); expect_("br_valid", S_VLD, 0);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("br_inst", S_INST, 32'h8C220004); expect_("br_pc", S_IDPC, 32'h10);
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    expect_("nrdy_inst", S_INST, 32'h8C220004); expect_("nrdy_addr", S_ADDR, 32'h10);
    expect_("nrdy_cnt", S_CNT, 4);
    cyc(1, 0, 0, 0, 0, 1);

    cyc(1, 0, 0, 1, 32'h00000080, 1);
    cyc(1, 0, 0, 0, 0, 1);
    expect_("oob_halted", S_HALT, 1); expect_("oob_rerr", S_RERR, 1);
    expect_("oob_cnt", S_CNT, 5); expect_("oob_valid", S_VLD, 0);
    cyc(1, 1, 0, 0, 0, 1);
    expect_("oob_clr_rerr", S_RERR, 0); expect_("oob_busy", S_BUSY, 1);
    cyc(1, 0, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    expect_("mrst_valid", S_VLD, 0); expect_("mrst_inst", S_INST, 0);
    expect_("mrst_pc", S_IDPC, 0); expect_("mrst_cnt", S_CNT, 0);
    expect_("mrst_busy", S_BUSY, 0); expect_("mrst_addr", S_ADDR, 0);

    fill_mem();
    for (int n = 0; n < 3000; n++) begin
      bit rn, st, fz, br, rd;
      rn = ($urandom_range(0, 199) != 0);
      if (!rn) fill_mem();
      st = ($urandom_range(0, 19) == 0);
      fz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 9) < 7);
      cyc(rn, st, fz, br, 32'($urandom_range(0, 159)), rd);
    end

    cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the MIPS pipeline. It owns the PC and drives the word-addressed, combinational-read instruction memory. It captures the fetched word into an IF/ID register with a valid/ready handshake toward decode. It handles hazard freeze, branch redirect with flush, and halt on a HALT opcode or an out-of-range PC.

Parameters:
MEM_WORDS, 32, instruction memory depth in words; fetch index is pc>>2
RESET_PC, 32'h0000_0000, PC loaded on reset and on restart
HALT_OPCODE, 6'b111111, opcode (inst[31:26]) that stops fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; IDLE/HALT -> RUN
freeze  in  1  hazard stall from hazard unit; holds PC and IF/ID
branch_taken  in  1  redirect request from EXE stage
branch_addr  in  32  redirect target (byte address)
imem_addr  out  32  byte address to instruction memory (= pc)
imem_data  in  32  instruction word, valid same cycle as imem_addr
id_valid  out  1  IF/ID register holds a live instruction
id_ready  in  1  decode accepts IF/ID contents this cycle
id_pc  out  32  pc+4 of the held instruction
id_inst  out  32  held instruction word
busy  out  1  state == RUN
halted  out  1  state == HALT
range_err  out  1  sticky; set when halt was caused by out-of-range PC
fetch_count  out  16  instructions issued since last start, saturating

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, id_valid=0, id_inst=0, id_pc=0, range_err=0, fetch_count=0. busy=0, halted=0. Reset mid-operation discards IF/ID contents immediately.
- imem_addr = pc combinationally in all states. Memory read is zero-latency.
- States:
  - IDLE: start -> RUN. All other inputs ignored.
  - RUN: described below.
  - HALT: start -> RUN with pc=RESET_PC, fetch_count=0, range_err=0. branch_taken ignored.
- advance = (state==RUN) & !freeze & !branch_taken & (!id_valid | id_ready).
- RUN priority, highest first:
  1. branch_taken: pc = {branch_addr[31:2],2'b00} (misalignment silently dropped). id_valid=0 and id_inst=0 (flush wrong-path). Applies even when freeze=1. No count change.
  2. (pc>>2) >= MEM_WORDS with advance: state=HALT, range_err=1, id_valid=0, nothing issued.
  3. advance with imem_data[31:26]==HALT_OPCODE: state=HALT. HALT word is not issued. id_valid=0. pc holds.
  4. advance (normal): id_inst=imem_data, id_pc=pc+4, id_valid=1, pc=pc+4 (32-bit wrap), fetch_count+=1 (saturates at 16'hFFFF).
  5. Otherwise, if id_valid & id_ready & freeze: id_valid=0 (consumed, not refilled). Otherwise hold.
- One issue per cycle maximum. Throughput is 1 instr/cycle when freeze=0 and id_ready=1.
- Branch to an out-of-range target is accepted. Error is detected at the next advance.
- In IDLE/HALT: id_valid=0 after the entry cycle. id_inst/id_pc keep their last values.
- start while in RUN: ignored.

Test Plan:
- Reset then start, memory[0]=32'h8001060A, memory[1]=32'h04011000, id_ready=1 -> cycle after start: id_inst=8001060A, id_pc=4. Next cycle: id_inst=04011000, id_pc=8. fetch_count=2.
- freeze=1 for 3 cycles mid-stream -> pc, id_inst, id_pc held. id_valid drops after first id_ready. Fetch resumes at same pc on release, with no skipped or duplicated word.
- branch_taken=1 with branch_addr=32'h0000000E while freeze=1 -> next cycle pc=0x0C, id_valid=0. Following cycle id_inst=memory[3], id_pc=0x10.
- id_ready=0 for 2 cycles with id_valid=1 -> id_inst stable, pc not incremented, fetch_count unchanged.
- memory[2]=32'hFC000000 -> after issuing words 0,1: halted=1, busy=0, id_valid=0, fetch_count=2, range_err=0. start -> refetch from pc=0, fetch_count restarts at 1.
- branch to 32'h00000080 (MEM_WORDS=32) -> next cycle halted=1, range_err=1, nothing issued. rst_n=0 mid-RUN -> next cycle all outputs at reset values.
